// File: rtl/bargraph_meter.sv
// bargraph_meter: peak-hold bargraph level meter with decaying level display.
// Optional feature: define BARGRAPH_PEAK_EN to build the held-peak register,
// hold counter and peak segment overlay; otherwise peak is tied to 0.
module bargraph_meter #(
    parameter int WIDTH       = 16,
    parameter int DECAY_TICKS = 10,
    parameter int HOLD_TICKS  = 100,
    parameter int LW          = $clog2(WIDTH + 1)
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             mode,
    input  logic             freeze,
    output logic [WIDTH-1:0] out,
    output logic [LW-1:0]    level,
    output logic [LW-1:0]    peak
);
    localparam int DCW = $clog2(DECAY_TICKS + 1);

    logic [LW-1:0]    w_raw;
    logic [LW-1:0]    w_level_nx;
    logic [DCW-1:0]   w_dcnt_nx;
    logic [WIDTH-1:0] w_out;
    logic [LW-1:0]    r_level;
    logic [DCW-1:0]   r_dcnt;

    // Raw request: position of the highest set input bit, 1-based, 0 when idle.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < WIDTH; i++)
            if (in[i]) w_raw = LW'(i + 1);
    end

    // Next level: jump up to raw immediately, otherwise step down once per decay period.
    always_comb begin
        w_level_nx = r_level;
        w_dcnt_nx  = '0;
        if (w_raw < r_level) begin
            if (r_dcnt == DCW'(DECAY_TICKS - 1))
                w_level_nx = r_level - 1'b1;
            else
                w_dcnt_nx = r_dcnt + 1'b1;
        end else begin
            w_level_nx = w_raw;
        end
    end

    // Level and decay counter registers; freeze holds everything.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
            r_dcnt  <= '0;
        end else if (!freeze) begin
            r_level <= w_level_nx;
            r_dcnt  <= w_dcnt_nx;
        end
    end

`ifdef BARGRAPH_PEAK_EN
    localparam int HCW = $clog2(HOLD_TICKS + 1);

    logic [LW-1:0]  r_peak;
    logic [HCW-1:0] r_hcnt;

    // Peak hold: capture new maxima, then after the hold time fall to the current level.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_peak <= '0;
            r_hcnt <= '0;
        end else if (!freeze) begin
            if (w_raw >= r_peak) begin
                r_peak <= w_raw;
                r_hcnt <= '0;
            end else if (r_hcnt == HCW'(HOLD_TICKS - 1)) begin
                r_peak <= w_level_nx;
                r_hcnt <= '0;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    assign peak = r_peak;
`else
    assign peak = '0;
`endif

    // Segment drive: bar or dot for the level, plus the peak dot overlay (never matches when peak is 0).
    always_comb begin
        w_out = '0;
        for (int i = 0; i < WIDTH; i++)
            w_out[i] = (mode ? (LW'(i + 1) == r_level) : (LW'(i) < r_level)) | (LW'(i + 1) == peak);
    end

    assign level = r_level;
    assign out   = w_out;
endmodule

// File: tb/tb_bargraph_meter.sv
// tb_bargraph_meter: directed self-checking bench for bargraph_meter (WIDTH=16).
module tb_bargraph_meter;
    localparam bit PK =
`ifdef BARGRAPH_PEAK_EN
        1'b1;
`else
        1'b0;
`endif

    logic        hz100 = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_v = '0;
    logic        mode = 1'b0;
    logic        freeze = 1'b0;
    logic [15:0] out_v;
    logic [4:0]  level_v;
    logic [4:0]  peak_v;
    int          nchk = 0;
    int          nerr = 0;

    bargraph_meter #(.WIDTH(16), .DECAY_TICKS(10), .HOLD_TICKS(100)) dut (
        .hz100(hz100), .reset(reset), .in(in_v), .mode(mode), .freeze(freeze),
        .out(out_v), .level(level_v), .peak(peak_v)
    );

    always #5 hz100 = ~hz100;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hz100);
            #1;
        end
    endtask

    task automatic do_reset();
        in_v = '0; mode = 1'b0; freeze = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    endtask

    task automatic test_reset();
        reset = 1'b0; in_v = 16'hFFFF; freeze = 1'b1;
        #1;
        nchk++; if (out_v !== 16'h0) begin nerr++; $display("FAIL rst_out actual=%h required=0000", out_v); end
        nchk++; if (level_v !== 5'd0) begin nerr++; $display("FAIL rst_level actual=%0d required=0", level_v); end
        nchk++; if (peak_v !== 5'd0) begin nerr++; $display("FAIL rst_peak actual=%0d required=0", peak_v); end
        tick(2);
        nchk++; if (level_v !== 5'd0) begin nerr++; $display("FAIL rst_dominates actual=%0d required=0", level_v); end
        freeze = 1'b0;
        reset = 1'b1;
        tick(1);
        nchk++; if (level_v !== 5'd16) begin nerr++; $display("FAIL rel_level actual=%0d required=16", level_v); end
        nchk++; if (peak_v !== (PK ? 5'd16 : 5'd0)) begin nerr++; $display("FAIL rel_peak actual=%0d required=%0d", peak_v, PK ? 16 : 0); end
        nchk++; if (out_v !== 16'hFFFF) begin nerr++; $display("FAIL rel_out actual=%h required=ffff", out_v); end
    endtask

    task automatic test_decay();
        do_reset();
        in_v = 16'h0080;
        tick(1);
        nchk++; if (level_v !== 5'd8) begin nerr++; $display("FAIL dec_start actual=%0d required=8", level_v); end
        nchk++; if (out_v !== 16'h00FF) begin nerr++; $display("FAIL dec_bar actual=%h required=00ff", out_v); end
        in_v = '0;
        tick(9);
        nchk++; if (level_v !== 5'd8) begin nerr++; $display("FAIL dec_9 actual=%0d required=8", level_v); end
        tick(1);
        nchk++; if (level_v !== 5'd7) begin nerr++; $display("FAIL dec_10 actual=%0d required=7", level_v); end
        tick(69);
        nchk++; if (level_v !== 5'd1) begin nerr++; $display("FAIL dec_79 actual=%0d required=1", level_v); end
        tick(1);
        nchk++; if (level_v !== 5'd0) begin nerr++; $display("FAIL dec_80 actual=%0d required=0", level_v); end
        tick(25);
        nchk++; if (level_v !== 5'd0) begin nerr++; $display("FAIL dec_floor actual=%0d required=0", level_v); end
    endtask

    task automatic test_retrigger();
        do_reset();
        in_v = 16'h0010;
        tick(1);
        in_v = '0;
        tick(4);
        nchk++; if (level_v !== 5'd5) begin nerr++; $display("FAIL rtg_mid actual=%0d required=5", level_v); end
        in_v = 16'h0400;
        tick(1);
        nchk++; if (level_v !== 5'd11) begin nerr++; $display("FAIL rtg_jump actual=%0d required=11", level_v); end
        in_v = '0;
        tick(9);
        nchk++; if (level_v !== 5'd11) begin nerr++; $display("FAIL rtg_hold9 actual=%0d required=11", level_v); end
        tick(1);
        nchk++; if (level_v !== 5'd10) begin nerr++; $display("FAIL rtg_step actual=%0d required=10", level_v); end
    endtask

    task automatic test_hold();
        do_reset();
        in_v = 16'h0800;
        tick(1);
        in_v = '0;
        tick(99);
        nchk++; if (peak_v !== (PK ? 5'd12 : 5'd0)) begin nerr++; $display("FAIL hold_99_peak actual=%0d required=%0d", peak_v, PK ? 12 : 0); end
        nchk++; if (level_v !== 5'd3) begin nerr++; $display("FAIL hold_99_level actual=%0d required=3", level_v); end
        nchk++; if (out_v !== (PK ? 16'h0807 : 16'h0007)) begin nerr++; $display("FAIL hold_99_out actual=%h required=%h", out_v, PK ? 16'h0807 : 16'h0007); end
        tick(1);
        nchk++; if (level_v !== 5'd2) begin nerr++; $display("FAIL hold_100_level actual=%0d required=2", level_v); end
        nchk++; if (peak_v !== (PK ? 5'd2 : 5'd0)) begin nerr++; $display("FAIL hold_100_peak actual=%0d required=%0d", peak_v, PK ? 2 : 0); end
        nchk++; if (out_v !== 16'h0003) begin nerr++; $display("FAIL hold_100_out actual=%h required=0003", out_v); end
        mode = 1'b1;
        #1;
        nchk++; if (out_v !== 16'h0002) begin nerr++; $display("FAIL hold_dot_out actual=%h required=0002", out_v); end
        mode = 1'b0;
    endtask

    task automatic test_freeze();
        do_reset();
        in_v = 16'h0100;
        tick(1);
        in_v = '0;
        tick(30);
        mode = 1'b1;
        #1;
        nchk++; if (out_v !== (PK ? 16'h0120 : 16'h0020)) begin nerr++; $display("FAIL frz_dot_out actual=%h required=%h", out_v, PK ? 16'h0120 : 16'h0020); end
        nchk++; if (level_v !== 5'd6) begin nerr++; $display("FAIL frz_mode_level actual=%0d required=6", level_v); end
        freeze = 1'b1;
        tick(50);
        nchk++; if (level_v !== 5'd6) begin nerr++; $display("FAIL frz_level actual=%0d required=6", level_v); end
        nchk++; if (peak_v !== (PK ? 5'd9 : 5'd0)) begin nerr++; $display("FAIL frz_peak actual=%0d required=%0d", peak_v, PK ? 9 : 0); end
        in_v = 16'hFFFF;
        tick(5);
        nchk++; if (level_v !== 5'd6) begin nerr++; $display("FAIL frz_in_level actual=%0d required=6", level_v); end
        nchk++; if (peak_v !== (PK ? 5'd9 : 5'd0)) begin nerr++; $display("FAIL frz_in_peak actual=%0d required=%0d", peak_v, PK ? 9 : 0); end
        in_v = '0; freeze = 1'b0; mode = 1'b0;
        tick(9);
        nchk++; if (level_v !== 5'd6) begin nerr++; $display("FAIL frz_cnt_held actual=%0d required=6", level_v); end
        tick(1);
        nchk++; if (out_v !== (PK ? 16'h011F : 16'h001F)) begin nerr++; $display("FAIL frz_resume_out actual=%h required=%h", out_v, PK ? 16'h011F : 16'h001F); end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_v = 16'h2000;
        tick(1);
        in_v = '0;
        tick(55);
        #2;
        reset = 1'b0;
        #1;
        nchk++; if (level_v !== 5'd0 || peak_v !== 5'd0 || out_v !== 16'h0) begin nerr++; $display("FAIL arst_clear actual=%0d/%0d/%h required=0/0/0000", level_v, peak_v, out_v); end
        reset = 1'b1;
        in_v = 16'h0004;
        tick(1);
        nchk++; if (level_v !== 5'd3) begin nerr++; $display("FAIL arst_first actual=%0d required=3", level_v); end
        nchk++; if (peak_v !== (PK ? 5'd3 : 5'd0)) begin nerr++; $display("FAIL arst_peak actual=%0d required=%0d", peak_v, PK ? 3 : 0); end
        in_v = '0;
        tick(9);
        nchk++; if (level_v !== 5'd3) begin nerr++; $display("FAIL arst_dec9 actual=%0d required=3", level_v); end
        tick(1);
        nchk++; if (level_v !== 5'd2) begin nerr++; $display("FAIL arst_dec10 actual=%0d required=2", level_v); end
    endtask

    initial begin
        test_reset();
        test_decay();
        test_retrigger();
        test_hold();
        test_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
